// File: rtl/rename_regfile_pkg.sv
// Shared defaults and constants for the rename register file.
// Imported by the top and the read-port lookup.
package rename_regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam logic BUSY    = 1'b1;
    localparam logic FREE    = 1'b0;

endpackage

// File: rtl/regfile_read_port.sv
// Single read-port lookup into the rename table.
// Also holds the same-cycle commit bypass mux.
module regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREG  = NREG_DEF,
    parameter  int TAG_W = TAG_W_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       req,
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0][TAG_W-1:0] tags,
    input  logic [NREG-1:0]            busy,
    input  logic                       cm_valid,
    input  logic [AW-1:0]              cm_addr,
    input  logic [TAG_W-1:0]           cm_tag,
    input  logic [XLEN-1:0]            cm_data,
    output logic                       valid,
    output logic                       pend,
    output logic [XLEN-1:0]            data,
    output logic [TAG_W-1:0]           tag
);

    logic idle;
    logic hit;
    logic sel_free;
    logic sel_byp;
    logic sel_wait;

    // Exactly one of the four selects is high at any time.
    assign idle     = rst | ~req;
    assign hit      = cm_valid & rdy & (cm_addr == addr)
                    & (cm_tag == tags[addr]);
    assign sel_free = ~idle & ~busy[addr];
    assign sel_byp  = ~idle & busy[addr] & hit;
    assign sel_wait = ~idle & busy[addr] & ~hit;

    always_comb begin
        valid = INVALID;
        pend  = FREE;
        data  = '0;
        tag   = '0;
        unique case (1'b1)
            sel_free: begin
                valid = VALID;
                data  = regs[addr];
            end
            sel_byp: begin
                valid = VALID;
                data  = cm_data;
            end
            sel_wait: begin
                valid = VALID;
                pend  = BUSY;
                tag   = tags[addr];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/tag rename table.
// Commit, rename and flush update state; NRD combinational read ports.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREG  = NREG_DEF,
    parameter  int TAG_W = TAG_W_DEF,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [NRD-1:0]       rd_req,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD-1:0]       rd_valid,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD*TAG_W-1:0] rd_tag,
    input  logic                 ren_valid,
    input  logic [AW-1:0]        ren_addr,
    input  logic [TAG_W-1:0]     ren_tag,
    input  logic                 cm_valid,
    input  logic [AW-1:0]        cm_addr,
    input  logic [TAG_W-1:0]     cm_tag,
    input  logic [XLEN-1:0]      cm_data,
    input  logic                 flush
);

    logic [NREG-1:0][XLEN-1:0]  regs;
    logic [NREG-1:0][TAG_W-1:0] tags;
    logic [NREG-1:0]            busy;

    logic cm_we;
    logic ren_we;

    assign cm_we  = cm_valid & (cm_addr != '0);
    assign ren_we = ren_valid & (ren_addr != '0) & ~flush;

    // Rename is applied after commit so it wins on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
            tags <= '0;
            busy <= '0;
        end else if (rdy) begin
            if (cm_we) begin
                regs[cm_addr] <= cm_data;
                if (tags[cm_addr] == cm_tag)
                    busy[cm_addr] <= FREE;
            end
            if (flush)
                busy <= '0;
            else if (ren_we) begin
                tags[ren_addr] <= ren_tag;
                busy[ren_addr] <= BUSY;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W)
        ) u_rp (
            .rst      (rst),
            .rdy      (rdy),
            .req      (rd_req[i]),
            .addr     (rd_addr[i*AW +: AW]),
            .regs     (regs),
            .tags     (tags),
            .busy     (busy),
            .cm_valid (cm_valid),
            .cm_addr  (cm_addr),
            .cm_tag   (cm_tag),
            .cm_data  (cm_data),
            .valid    (rd_valid[i]),
            .pend     (rd_busy[i]),
            .data     (rd_data[i*XLEN +: XLEN]),
            .tag      (rd_tag[i*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Scenario and randomized checks of rename_regfile against a
// register/tag/busy array model built from the rename rules.
module tb_rename_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 0;
    logic                 rst;
    logic                 rdy;
    logic [NRD-1:0]       rd_req;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD-1:0]       rd_valid;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic                 ren_valid;
    logic [AW-1:0]        ren_addr;
    logic [TAG_W-1:0]     ren_tag;
    logic                 cm_valid;
    logic [AW-1:0]        cm_addr;
    logic [TAG_W-1:0]     cm_tag;
    logic [XLEN-1:0]      cm_data;
    logic                 flush;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        v;
        logic        b;
        logic [31:0] d;
        logic [3:0]  t;
    } rd_t;

    logic [31:0] m_regs [NREG];
    logic [3:0]  m_tag  [NREG];
    bit          m_busy [NREG];

    rename_regfile #(
        .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_tag(rd_tag),
        .ren_valid(ren_valid), .ren_addr(ren_addr),
        .ren_tag(ren_tag), .cm_valid(cm_valid),
        .cm_addr(cm_addr), .cm_tag(cm_tag),
        .cm_data(cm_data), .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic rd_t mk(logic v, logic b,
                               logic [31:0] d, logic [3:0] t);
        rd_t r;
        r.v = v; r.b = b; r.d = d; r.t = t;
        return r;
    endfunction

    function automatic rd_t got(int p);
        return mk(rd_valid[p], rd_busy[p],
                  rd_data[p*XLEN +: XLEN], rd_tag[p*TAG_W +: TAG_W]);
    endfunction

    function automatic rd_t model_rd(logic req, int a);
        if (rst || !req) return mk(0, 0, 0, 0);
        if (!m_busy[a]) return mk(1, 0, m_regs[a], 0);
        if (cm_valid && rdy && int'(cm_addr) == a && cm_tag == m_tag[a])
            return mk(1, 0, cm_data, 0);
        return mk(1, 1, 0, m_tag[a]);
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
            end
        end else if (rdy) begin
            if (cm_valid && cm_addr != 0) begin
                m_regs[cm_addr] = cm_data;
                if (m_tag[cm_addr] == cm_tag) m_busy[cm_addr] = 0;
            end
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 0;
            end else if (ren_valid && ren_addr != 0) begin
                m_tag[ren_addr]  = ren_tag;
                m_busy[ren_addr] = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0;
        rd_req = '0; rd_addr = '0;
        ren_valid = 0; ren_addr = '0; ren_tag = '0;
        cm_valid = 0; cm_addr = '0; cm_tag = '0; cm_data = '0;
    endtask

    task automatic rd(int p, int a);
        rd_req[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic ren(int a, int t);
        ren_valid = 1; ren_addr = AW'(a); ren_tag = TAG_W'(t);
    endtask

    task automatic cm(int a, int t, logic [31:0] d);
        cm_valid = 1; cm_addr = AW'(a); cm_tag = TAG_W'(t); cm_data = d;
    endtask

    task automatic test_reset();
        rd_t e;
        idle(); rst = 1; rd(0, 5); rd(1, 5);
        #1;
        e = mk(0, 0, 0, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL rst_outputs got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 5);
        #1;
        e = mk(1, 0, 0, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL reset_x5 got=%h exp=%h", got(0), e); end
    endtask

    task automatic test_commit_bypass();
        rd_t e;
        idle(); ren(5, 3); rd(0, 5);
        #1;
        e = mk(1, 0, 0, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL ren_not_visible got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 5);
        #1;
        e = mk(1, 1, 0, 3);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x5_busy got=%h exp=%h", got(0), e); end
        cm(5, 3, 32'hDEADBEEF);
        #1;
        e = mk(1, 0, 32'hDEADBEEF, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x5_bypass got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 5);
        #1;
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x5_stored got=%h exp=%h", got(0), e); end
    endtask

    task automatic test_overlap_rename();
        rd_t e;
        idle(); ren(7, 2); tick();
        idle(); ren(7, 6); tick();
        idle(); cm(7, 2, 32'h11); rd(1, 7);
        #1;
        e = mk(1, 1, 0, 6);
        total++; if (got(1) !== e) begin bad++;
            $display("FAIL x7_stale_nobyp got=%h exp=%h", got(1), e); end
        tick();
        idle(); rd(1, 7);
        #1;
        total++; if (got(1) !== e) begin bad++;
            $display("FAIL x7_still_busy got=%h exp=%h", got(1), e); end
        cm(7, 6, 32'h22);
        #1;
        e = mk(1, 0, 32'h22, 0);
        total++; if (got(1) !== e) begin bad++;
            $display("FAIL x7_bypass got=%h exp=%h", got(1), e); end
        tick();
        idle(); rd(1, 7);
        #1;
        total++; if (got(1) !== e) begin bad++;
            $display("FAIL x7_stored got=%h exp=%h", got(1), e); end
    endtask

    task automatic test_same_cycle();
        rd_t e;
        idle(); ren(9, 1); tick();
        idle(); ren(9, 4); cm(9, 1, 32'h55); rd(0, 9);
        #1;
        e = mk(1, 0, 32'h55, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x9_bypass got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 9);
        #1;
        e = mk(1, 1, 0, 4);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x9_rename_wins got=%h exp=%h", got(0), e); end
        flush = 1; tick();
        idle(); rd(0, 9);
        #1;
        e = mk(1, 0, 32'h55, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x9_regs got=%h exp=%h", got(0), e); end
    endtask

    task automatic test_flush();
        rd_t e;
        int addrs [5] = '{1, 2, 3, 4, 10};
        for (int i = 1; i <= 4; i++) begin
            idle(); ren(i, i); tick();
        end
        idle(); flush = 1; ren(10, 7); cm(2, 2, 32'h77); rd(0, 1);
        #1;
        e = mk(1, 1, 0, 1);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x1_prefl got=%h exp=%h", got(0), e); end
        tick();
        for (int i = 0; i < 5; i++) begin
            idle(); rd(i % 2, addrs[i]);
            #1;
            e = (addrs[i] == 2) ? mk(1, 0, 32'h77, 0) : mk(1, 0, 0, 0);
            total++; if (got(i % 2) !== e) begin bad++;
                $display("FAIL flush_x%0d got=%h exp=%h",
                         addrs[i], got(i % 2), e); end
        end
    endtask

    task automatic test_x0_rdy();
        rd_t e;
        idle(); ren(0, 5); tick();
        idle(); cm(0, 0, 32'hFF); rd(0, 0);
        #1;
        e = mk(1, 0, 0, 0);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x0_cm_cycle got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 0);
        #1;
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x0_zero got=%h exp=%h", got(0), e); end
        rdy = 0; ren(3, 9); tick();
        idle(); rd(0, 3); rd(1, 3);
        #1;
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL x3_frozen got=%h exp=%h", got(0), e); end
        total++; if (got(1) !== got(0)) begin bad++;
            $display("FAIL x3_ports got=%h exp=%h", got(1), got(0)); end
        ren(3, 9); tick();
        idle(); rdy = 0; cm(3, 9, 32'hAA); rd(0, 3);
        #1;
        e = mk(1, 1, 0, 9);
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL rdy0_nobyp got=%h exp=%h", got(0), e); end
        tick();
        idle(); rd(0, 3);
        #1;
        total++; if (got(0) !== e) begin bad++;
            $display("FAIL rdy0_no_cm got=%h exp=%h", got(0), e); end
    endtask

    task automatic test_random();
        rd_t e;
        int a [NRD];
        idle(); rst = 1; tick();
        for (int n = 0; n < 400; n++) begin
            idle();
            rst   = ($urandom_range(0, 99) < 2);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 19) == 0);
            ren_valid = $urandom_range(0, 1);
            ren_addr  = AW'($urandom_range(0, 7));
            ren_tag   = TAG_W'($urandom);
            cm_valid  = $urandom_range(0, 1);
            cm_addr   = AW'($urandom_range(0, 7));
            cm_tag    = ($urandom_range(0, 9) < 7) ? m_tag[cm_addr]
                                                   : TAG_W'($urandom);
            cm_data   = $urandom;
            for (int p = 0; p < NRD; p++) begin
                a[p] = $urandom_range(0, 7);
                rd_req[p] = ($urandom_range(0, 9) != 0);
                rd_addr[p*AW +: AW] = AW'(a[p]);
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                e = model_rd(rd_req[p], a[p]);
                total++; if (got(p) !== e) begin bad++;
                    $display("FAIL rand n=%0d p=%0d got=%h exp=%h",
                             n, p, got(p), e); end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_commit_bypass();
        test_overlap_rename();
        test_same_cycle();
        test_flush();
        test_x0_rdy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
